cnt_checker: RTL and testbench

Sequence checker for a free-running up-counter output (e.g. the `countor` 4-bit `cnt` bus). It samples a count stream, acquires lock after a run of consecutive +1 steps, and then flags every deviation from the modulo-2^WIDTH increment. It sits beside the counter as a self-check block in simulation and on board, and feeds error and status bits to LEDs or a debug register.

---
 rtl/cnt_checker.sv | 115 +++++++++++
 tb/tb_cnt_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_checker.sv
// cnt_checker: locks onto a +1 count stream and
// flags every break in the modulo-2^WIDTH sequence.
module cnt_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             in_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LL = 4'(LOCK_LEN);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [ERR_W-1:0] ONE_E = ERR_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       run;
  logic [3:0]       run_nx;
  logic [WIDTH-1:0] exp_v;
  logic             match;
  logic             err_ev;
  logic             wrap_ev;

  assign exp_v   = prev + ONE_W;
  assign match   = (cnt_in == exp_v);
  assign run_nx  = run + 4'd1;
  assign err_ev  = in_valid && (state == LOCKED)
                && !match;
  assign wrap_ev = in_valid && (state == LOCKED)
                && match && (prev == '1);
  assign locked  = (state == LOCKED);

  // Sequence FSM: track previous sample and run length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prev  <= '0;
      run   <= '0;
    end else if (in_valid) begin
      prev <= cnt_in;
      case (state)
        IDLE: begin
          run   <= '0;
          state <= SEARCH;
        end
        SEARCH: begin
          if (match) begin
            if (run_nx == LL) begin
              run   <= '0;
              state <= LOCKED;
            end else begin
              run <= run_nx;
            end
          end else begin
            run <= '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            run   <= '0;
            state <= SEARCH;
          end
        end
        default: begin
          run   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Error reporting; clr still records a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err_ev;
      if (clr) begin
        err_sticky <= err_ev;
        err_cnt    <= err_ev ? ONE_E : '0;
      end else if (err_ev) begin
        err_sticky <= 1'b1;
        if (err_cnt != '1)
          err_cnt <= err_cnt + ONE_E;
      end
    end
  end

  // Wrap counter: verified max-to-0 steps while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt <= '0;
    end else if (clr) begin
      wrap_cnt <= wrap_ev ? ONE_E : '0;
    end else if (wrap_ev) begin
      wrap_cnt <= wrap_cnt + ONE_E;
    end
  end

endmodule

// File: tb/tb_cnt_checker.sv
// tb_cnt_checker: directed vectors for cnt_checker,
// default and (ERR_W=2, LOCK_LEN=1) instances.
module tb_cnt_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] c0 = '0;
  logic       v0 = 1'b0;
  logic       k0 = 1'b0;
  logic       lk0, ep0, es0;
  logic [7:0] ec0, wc0;

  logic [3:0] c1 = '0;
  logic       v1 = 1'b0;
  logic       k1 = 1'b0;
  logic       lk1, ep1, es1;
  logic [1:0] ec1, wc1;

  int errs = 0;
  int checks = 0;
  int any_ep;
  logic [3:0] pv;

  always #5 clk = ~clk;

  cnt_checker u0 (
    .clk(clk), .rst_n(rst_n),
    .cnt_in(c0), .in_valid(v0), .clr(k0),
    .locked(lk0), .err_pulse(ep0),
    .err_sticky(es0), .err_cnt(ec0),
    .wrap_cnt(wc0)
  );

  cnt_checker #(
    .WIDTH(4), .LOCK_LEN(1), .ERR_W(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .cnt_in(c1), .in_valid(v1), .clr(k1),
    .locked(lk1), .err_pulse(ep1),
    .err_sticky(es1), .err_cnt(ec1),
    .wrap_cnt(wc1)
  );

  task automatic chk(input string tag,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d",
               tag, act, exp);
    end
  endtask

  task automatic step0(input logic v,
                       input logic [3:0] c,
                       input logic k);
    v0 = v; c0 = c; k0 = k;
    @(posedge clk);
    #1;
    v0 = 1'b0; k0 = 1'b0;
  endtask

  task automatic step1(input logic [3:0] c);
    v1 = 1'b1; c1 = c;
    @(posedge clk);
    #1;
    v1 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst_locked", int'(lk0), 0);
    chk("rst_errcnt", int'(ec0), 0);
    chk("rst_wrap", int'(wc0), 0);
    chk("rst_sticky", int'(es0), 0);

    for (int i = 0; i < 40; i++) begin
      step0(1'b1, 4'(i), 1'b0);
      if (i == 3) chk("lock_s3", int'(lk0), 0);
      if (i == 4) chk("lock_s4", int'(lk0), 1);
      if (i == 16) chk("wrap_s16", int'(wc0), 1);
    end
    chk("wrap_40", int'(wc0), 2);
    chk("err_40", int'(ec0), 0);

    for (int i = 40; i < 55; i++)
      step0(1'b1, 4'(i), 1'b0);
    chk("at6_locked", int'(lk0), 1);
    chk("wrap_3", int'(wc0), 3);
    step0(1'b1, 4'd9, 1'b0);
    chk("gl_pulse", int'(ep0), 1);
    chk("gl_errcnt", int'(ec0), 1);
    chk("gl_sticky", int'(es0), 1);
    chk("gl_locked", int'(lk0), 0);
    step0(1'b1, 4'd10, 1'b0);
    chk("gl_pulse_end", int'(ep0), 0);
    step0(1'b1, 4'd11, 1'b0);
    step0(1'b1, 4'd12, 1'b0);
    chk("gl_relock_12", int'(lk0), 0);
    step0(1'b1, 4'd13, 1'b0);
    chk("gl_relock_13", int'(lk0), 1);

    do_reset();
    any_ep = 0;
    begin
      logic [3:0] sv [7];
      sv = '{4'd3, 4'd4, 4'd8, 4'd9,
             4'd10, 4'd11, 4'd12};
      for (int i = 0; i < 7; i++) begin
        step0(1'b1, sv[i], 1'b0);
        if (ep0) any_ep = 1;
        if (i == 5) chk("sr_lock_11", int'(lk0), 0);
      end
    end
    chk("sr_lock_12", int'(lk0), 1);
    chk("sr_no_pulse", any_ep, 0);
    chk("sr_errcnt", int'(ec0), 0);

    for (int i = 13; i < 22; i++)
      step0(1'b1, 4'(i), 1'b0);
    chk("gap_wrap", int'(wc0), 1);
    any_ep = 0;
    for (int i = 0; i < 3; i++) begin
      step0(1'b0, 4'd0, 1'b0);
      if (ep0) any_ep = 1;
      chk("gap_idle_lock", int'(lk0), 1);
    end
    step0(1'b1, 4'd6, 1'b0);
    if (ep0) any_ep = 1;
    chk("gap_no_pulse", any_ep, 0);
    chk("gap_locked", int'(lk0), 1);
    chk("gap_errcnt", int'(ec0), 0);

    pv = 4'd6;
    for (int e = 0; e < 3; e++) begin
      pv = pv + 4'd3;
      step0(1'b1, pv, 1'b0);
      for (int j = 0; j < 4; j++) begin
        pv = pv + 4'd1;
        step0(1'b1, pv, 1'b0);
      end
    end
    chk("clr_pre_err", int'(ec0), 3);
    chk("clr_pre_lock", int'(lk0), 1);
    pv = pv + 4'd3;
    step0(1'b1, pv, 1'b1);
    chk("clr_err_cnt", int'(ec0), 1);
    chk("clr_err_sticky", int'(es0), 1);
    chk("clr_err_pulse", int'(ep0), 1);
    for (int j = 0; j < 4; j++) begin
      pv = pv + 4'd1;
      step0(1'b1, pv, 1'b0);
    end
    chk("clr_relock", int'(lk0), 1);
    while (pv != 4'hF) begin
      pv = pv + 4'd1;
      step0(1'b1, pv, 1'b0);
    end
    pv = 4'd0;
    step0(1'b1, pv, 1'b1);
    chk("clr_wrap_same", int'(wc0), 1);
    chk("clr_wrap_err", int'(ec0), 0);
    step0(1'b0, 4'd0, 1'b1);
    chk("clr_only_err", int'(ec0), 0);
    chk("clr_only_sticky", int'(es0), 0);
    chk("clr_only_wrap", int'(wc0), 0);
    chk("clr_keep_lock", int'(lk0), 1);

    do_reset();
    step1(4'd0);
    chk("s1_idle", int'(lk1), 0);
    step1(4'd1);
    chk("s1_lock", int'(lk1), 1);
    pv = 4'd1;
    for (int e = 1; e <= 5; e++) begin
      pv = pv + 4'd3;
      step1(pv);
      chk("sat_pulse", int'(ep1), 1);
      chk("sat_cnt", int'(ec1), (e > 3) ? 3 : e);
      pv = pv + 4'd1;
      step1(pv);
    end
    chk("sat_sticky", int'(es1), 1);
    chk("sat_locked", int'(lk1), 1);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_locked1", int'(lk1), 0);
    chk("ar_err1", int'(ec1), 0);
    chk("ar_sticky1", int'(es1), 0);
    chk("ar_pulse1", int'(ep1), 0);
    chk("ar_wrap1", int'(wc1), 0);
    chk("ar_locked0", int'(lk0), 0);
    #2;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
